// File: rtl/avalon_mm_master_q.sv
// avalon_mm_master_q: queued Avalon-MM master. Commands are buffered in a
// small FIFO and issued back-to-back onto the bus. Each transfer is either
// completed by WAITREQUEST low or aborted by the waitrequest timeout. Every
// command produces exactly one response pulse, in command order.
module avalon_mm_master_q #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rnw,
  input  logic                cmd_lock,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic [ADDR_W-1:0]   ADDRESS,
  output logic [DATA_W/8-1:0] BYTEENABLE,
  output logic                READ,
  output logic                WRITE,
  output logic [DATA_W-1:0]   WRITEDATA,
  output logic                BEGINTRANSFER,
  output logic                LOCK,
  input  logic [DATA_W-1:0]   READDATA,
  input  logic                WAITREQUEST
);

  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  // The wait counter only has to reach TIMEOUT-1: the edge that would take
  // it to TIMEOUT is the abort edge.
  localparam int WC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(DEPTH);

  typedef struct packed {
    logic              rnw;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } cmd_t;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WC_W-1:0]  wait_cnt;
  state_t           state;
  state_t           state_nxt;
  logic             q_empty;
  logic             push;
  logic             load;
  logic             done;
  logic             abort;

  assign q_empty   = (count == '0);
  assign cmd_ready = (count != FULL);
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign busy      = !q_empty || (state == ACCESS);

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, transfer end detection and head load decision.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          load      = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        done  = !WAITREQUEST;
        abort = (TIMEOUT != 0) && WAITREQUEST && (wait_cnt == WAIT_LAST);
        if (done || abort) begin
          // Zero-bubble: the next head goes straight onto the bus.
          if (!q_empty) load      = 1'b1;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Queue storage write port.
  always_ff @(posedge CLK) begin
    // NOTE: the storage array is not reset; which entries are live is defined
    // entirely by the pointers and count, which are.
    if (push) mem[wr_ptr] <= {cmd_rnw, cmd_lock, cmd_addr, cmd_wdata, cmd_be};
  end

  // Queue pointers and occupancy; a pop is the head being loaded onto the bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (load) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(load);
    end
  end

  // Bus registers, wait counter, lock tracking and response generation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ADDRESS       <= '0;
      BYTEENABLE    <= '0;
      WRITEDATA     <= '0;
      READ          <= 1'b0;
      WRITE         <= 1'b0;
      BEGINTRANSFER <= 1'b0;
      LOCK          <= 1'b0;
      wait_cnt      <= '0;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= '0;
    end else begin
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      BEGINTRANSFER <= 1'b0;
      if (done || abort) begin
        rsp_valid <= 1'b1;
        rsp_err   <= abort;
        rsp_rdata <= (done && READ) ? READDATA : '0;
        READ      <= 1'b0;
        WRITE     <= 1'b0;
      end else if (state == ACCESS && WAITREQUEST) begin
        wait_cnt <= wait_cnt + WC_W'(1);
      end
      if (load) begin
        ADDRESS       <= head.addr;
        BYTEENABLE    <= head.be;
        WRITEDATA     <= head.wdata;
        READ          <= head.rnw;
        WRITE         <= !head.rnw;
        LOCK          <= head.lock;
        BEGINTRANSFER <= 1'b1;
        wait_cnt      <= '0;
      end else if (state == IDLE) begin
        // An IDLE edge with nothing to load releases the lock: it is held
        // for exactly one idle cycle after a locked command.
        LOCK <= 1'b0;
      end
    end
  end

endmodule
